conv_window_feeder: RTL and testbench

//  Initiator side of the layer-1 convolution MAC interface. Consumes a raster pixel stream,

---
 rtl/conv_window_feeder.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_conv_window_feeder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_feeder.sv
// conv_window_feeder
// Feeds KxK convolution windows to the layer-1 MAC from a raster pixel stream.
// The image is zero padded by PAD pixels on every side; padding positions are
// generated internally, one per cycle, while interior positions wait for an
// input pixel. K-1 line buffers of PW entries hold the previous padded rows.
// Each completed window is presented for exactly one cycle on win_valid with
// the whole window on win_data; win_data then holds until the next window.
//
// Optional build macro:
//   CONV_FEEDER_COORD_EN - adds win_row / win_col outputs carrying the
//                          output-pixel coordinate of the current window.
module conv_window_feeder #(
    parameter int FEATURE_BW = 8,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int K          = 3,
    parameter int PAD        = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic                           px_valid,
    output logic                           px_ready,
    input  logic [FEATURE_BW-1:0]          px_data,
    output logic                           win_valid,
    output logic [K*K*FEATURE_BW-1:0]      win_data,
    output logic                           busy,
    output logic                           frame_done
`ifdef CONV_FEEDER_COORD_EN
    ,
    output logic [$clog2(IMG_H)-1:0]       win_row,
    output logic [$clog2(IMG_W)-1:0]       win_col
`endif
);

    localparam int PW  = IMG_W + 2 * PAD;
    localparam int PH  = IMG_H + 2 * PAD;
    localparam int RW  = $clog2(PH);
    localparam int CW  = $clog2(PW);
    localparam int WB  = K * K * FEATURE_BW;

    // Padded-coordinate landmarks, sized to the counters they are compared with
    localparam logic [RW-1:0] PR_ZERO = RW'(0);
    localparam logic [RW-1:0] PR_ONE  = RW'(1);
    localparam logic [RW-1:0] PR_MAX  = RW'(PH - 1);
    localparam logic [RW-1:0] PR_LO   = RW'(PAD);
    localparam logic [RW-1:0] PR_HI   = RW'(PH - PAD);
    localparam logic [RW-1:0] PR_WIN  = RW'(K - 1);
    localparam logic [CW-1:0] PC_ZERO = CW'(0);
    localparam logic [CW-1:0] PC_ONE  = CW'(1);
    localparam logic [CW-1:0] PC_MAX  = CW'(PW - 1);
    localparam logic [CW-1:0] PC_LO   = CW'(PAD);
    localparam logic [CW-1:0] PC_HI   = CW'(PW - PAD);
    localparam logic [CW-1:0] PC_WIN  = CW'(K - 1);

`ifdef CONV_FEEDER_COORD_EN
    localparam int ORW = $clog2(IMG_H);
    localparam int OCW = $clog2(IMG_W);
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Control state
    state_t                  state_r;
    logic [RW-1:0]           pr_r;
    logic [CW-1:0]           pc_r;
    logic                    px_ready_r;
    logic                    busy_r;
    logic                    frame_done_r;

    // Data path state
    logic [FEATURE_BW-1:0]   lb_r   [K-1][PW];    // lb_r[j] delays a value by (j+1) padded rows
    logic [FEATURE_BW-1:0]   hist_r [K][K-1];     // right-hand K-1 columns of the last window
    logic                    win_valid_r;
    logic [WB-1:0]           win_data_r;
`ifdef CONV_FEEDER_COORD_EN
    logic [ORW-1:0]          win_row_r;
    logic [OCW-1:0]          win_col_r;
`endif

    // Combinational helpers
    logic                    push_s;
    logic [FEATURE_BW-1:0]   push_val_s;
    logic                    last_col_s;
    logic                    last_pos_s;
    logic [RW-1:0]           pr_nxt_s;
    logic [CW-1:0]           pc_nxt_s;
    logic                    win_done_s;
    logic [FEATURE_BW-1:0]   col_in_s [K];        // col_in_s[j]: value of padded row pr-j, column pc
    logic [FEATURE_BW-1:0]   win_nxt_s [K][K];
    logic [WB-1:0]           win_flat_s;

    // True when a padded coordinate lies inside the real image
    function automatic logic is_interior(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return (r >= PR_LO) && (r < PR_HI) && (c >= PC_LO) && (c < PC_HI);
    endfunction

    // Decide whether a value is pushed this cycle and what it is (pixel or zero pad)
    always_comb begin
        push_s     = 1'b0;
        push_val_s = {FEATURE_BW{1'b0}};
        if (state_r == ST_SCAN) begin
            if (px_ready_r) begin
                push_s     = px_valid;
                push_val_s = px_data;
            end else begin
                push_s     = 1'b1;
                push_val_s = {FEATURE_BW{1'b0}};
            end
        end else begin
            push_s     = 1'b0;
            push_val_s = {FEATURE_BW{1'b0}};
        end
    end

    // Raster advance of the padded coordinate and window-completion test
    always_comb begin
        last_col_s = (pc_r == PC_MAX);
        last_pos_s = last_col_s && (pr_r == PR_MAX);
        pr_nxt_s   = pr_r;
        pc_nxt_s   = pc_r + PC_ONE;
        if (last_col_s) begin
            pc_nxt_s = PC_ZERO;
            if (pr_r == PR_MAX) begin
                pr_nxt_s = PR_ZERO;
            end else begin
                pr_nxt_s = pr_r + PR_ONE;
            end
        end else begin
            pr_nxt_s = pr_r;
        end
        win_done_s = push_s && (pr_r >= PR_WIN) && (pc_r >= PC_WIN);
    end

    // Incoming column: the new value plus the same column from the line buffers
    always_comb begin
        col_in_s[0] = push_val_s;
        for (int j = 1; j < K; j++) begin
            col_in_s[j] = lb_r[j-1][PW-1];
        end
    end

    // Next window: history columns shift left, incoming column enters on the right
    always_comb begin
        for (int kr = 0; kr < K; kr++) begin
            for (int kc = 0; kc < K - 1; kc++) begin
                win_nxt_s[kr][kc] = hist_r[kr][kc];
            end
            // Top row (kr=0) is the oldest padded row pr-K+1
            win_nxt_s[kr][K-1] = col_in_s[K-1-kr];
        end
    end

    // Flatten the next window onto the MAC bus layout
    always_comb begin
        win_flat_s = {WB{1'b0}};
        for (int kr = 0; kr < K; kr++) begin
            for (int kc = 0; kc < K; kc++) begin
                win_flat_s[(kr*K+kc)*FEATURE_BW +: FEATURE_BW] = win_nxt_s[kr][kc];
            end
        end
    end

    // Frame sequencing: IDLE -> SCAN -> DONE -> IDLE, with registered handshake outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            pr_r         <= PR_ZERO;
            pc_r         <= PC_ZERO;
            px_ready_r   <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r    <= ST_SCAN;
                        pr_r       <= PR_ZERO;
                        pc_r       <= PC_ZERO;
                        busy_r     <= 1'b1;
                        px_ready_r <= is_interior(PR_ZERO, PC_ZERO);
                    end
                end
                ST_SCAN: begin
                    if (push_s) begin
                        if (last_pos_s) begin
                            // Final window is emitted next cycle, alongside frame_done
                            state_r      <= ST_DONE;
                            pr_r         <= PR_ZERO;
                            pc_r         <= PC_ZERO;
                            px_ready_r   <= 1'b0;
                            frame_done_r <= 1'b1;
                        end else begin
                            pr_r       <= pr_nxt_s;
                            pc_r       <= pc_nxt_s;
                            px_ready_r <= is_interior(pr_nxt_s, pc_nxt_s);
                        end
                    end
                end
                ST_DONE: begin
                    state_r    <= ST_IDLE;
                    busy_r     <= 1'b0;
                    px_ready_r <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    pr_r       <= PR_ZERO;
                    pc_r       <= PC_ZERO;
                    busy_r     <= 1'b0;
                    px_ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Line buffers and window history shift once per push
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < K - 1; j++) begin
                for (int i = 0; i < PW; i++) begin
                    lb_r[j][i] <= {FEATURE_BW{1'b0}};
                end
            end
            for (int kr = 0; kr < K; kr++) begin
                for (int kc = 0; kc < K - 1; kc++) begin
                    hist_r[kr][kc] <= {FEATURE_BW{1'b0}};
                end
            end
        end else if (push_s) begin
            for (int j = 0; j < K - 1; j++) begin
                lb_r[j][0] <= col_in_s[j];
                for (int i = 1; i < PW; i++) begin
                    lb_r[j][i] <= lb_r[j][i-1];
                end
            end
            for (int kr = 0; kr < K; kr++) begin
                for (int kc = 0; kc < K - 1; kc++) begin
                    hist_r[kr][kc] <= win_nxt_s[kr][kc+1];
                end
            end
        end
    end

    // Window output register: one-cycle valid, data held until the next window
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_valid_r <= 1'b0;
            win_data_r  <= {WB{1'b0}};
`ifdef CONV_FEEDER_COORD_EN
            win_row_r   <= {ORW{1'b0}};
            win_col_r   <= {OCW{1'b0}};
`endif
        end else begin
            win_valid_r <= win_done_s;
            if (win_done_s) begin
                win_data_r <= win_flat_s;
`ifdef CONV_FEEDER_COORD_EN
                win_row_r  <= ORW'(pr_r - PR_WIN);
                win_col_r  <= OCW'(pc_r - PC_WIN);
`endif
            end
        end
    end

    assign px_ready   = px_ready_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign win_valid  = win_valid_r;
    assign win_data   = win_data_r;
`ifdef CONV_FEEDER_COORD_EN
    assign win_row    = win_row_r;
    assign win_col    = win_col_r;
`endif

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder at default parameters (28x28, K=3, PAD=1).
// A negedge monitor compares every emitted window with a padded-image model.
module tb_conv_window_feeder;

    localparam int BW   = 8;
    localparam int W    = 28;
    localparam int H    = 28;
    localparam int K    = 3;
    localparam int NWIN = 784;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          px_valid = 1'b0;
    logic [BW-1:0] px_data = 8'd0;
    logic          px_ready;
    logic          win_valid;
    logic [71:0]   win_data;
    logic          busy;
    logic          frame_done;
`ifdef CONV_FEEDER_COORD_EN
    logic [4:0]    win_row;
    logic [4:0]    win_col;
    logic [4:0]    row_first, col_first, row_29, col_29, row_last, col_last;
`endif

    int checks = 0;
    int failures = 0;

    // Monitor state
    logic        mon_clr = 1'b1;
    int          win_cnt, win_err, fd_cnt, fd_err;
    logic [71:0] first_win, last_win;

    int  cyc;
    bit  done;

    conv_window_feeder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .px_data    (px_data),
        .win_valid  (win_valid),
        .win_data   (win_data),
        .busy       (busy),
        .frame_done (frame_done)
`ifdef CONV_FEEDER_COORD_EN
        ,
        .win_row    (win_row),
        .win_col    (win_col)
`endif
    );

    always #5 clk = ~clk;

    // Expected window n: output pixel (n/W, n%W) covers image rows/cols -1..+1 around it
    function automatic logic [71:0] exp_win(input int n);
        logic [71:0] w;
        int orow, ocol, r, c;
        w = 72'd0;
        orow = n / W;
        ocol = n % W;
        for (int kr = 0; kr < K; kr++) begin
            for (int kc = 0; kc < K; kc++) begin
                r = orow + kr - 1;
                c = ocol + kc - 1;
                if (r >= 0 && r < H && c >= 0 && c < W)
                    w[(kr*K+kc)*BW +: BW] = 8'((r * W + c) % 256);
            end
        end
        return w;
    endfunction

    // Window monitor
    always @(negedge clk) begin
        if (mon_clr) begin
            win_cnt <= 0;
            win_err <= 0;
            fd_cnt  <= 0;
            fd_err  <= 0;
        end else begin
            if (win_valid) begin
                if (win_data !== exp_win(win_cnt)) win_err <= win_err + 1;
                if (win_cnt == 0) first_win <= win_data;
                last_win <= win_data;
`ifdef CONV_FEEDER_COORD_EN
                if (win_cnt == 0)  begin row_first <= win_row; col_first <= win_col; end
                if (win_cnt == 28) begin row_29 <= win_row; col_29 <= win_col; end
                row_last <= win_row;
                col_last <= win_col;
`endif
                win_cnt <= win_cnt + 1;
            end
            if (frame_done) begin
                fd_cnt <= fd_cnt + 1;
                if (!win_valid || win_cnt != NWIN - 1) fd_err <= fd_err + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        mon_clr = 1'b0;
    endtask

    // Runs one frame. start_at: SCAN cycle to re-pulse start (-1 none);
    // start_in_done: pulse start in the DONE cycle; abort_after: stop once that many windows seen (0 none)
    task automatic run_frame(input bit toggle, input int start_at, input bit start_in_done,
                             input int abort_after, output int ncyc, output bit fdone);
        int idx;
        bit rdy;
        idx = 0; ncyc = 0; fdone = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!fdone && ncyc < 3000) begin
            px_valid = toggle ? (ncyc % 2 == 0) : 1'b1;
            px_data  = 8'(idx % 256);
            start    = (ncyc == start_at);
            @(negedge clk);
            rdy = px_ready;
            @(posedge clk); #1;
            if (px_valid && rdy) idx++;
            ncyc++;
            if (frame_done) fdone = 1'b1;
            if (abort_after > 0 && win_cnt >= abort_after) break;
        end
        px_valid = 1'b0;
        start = start_in_done && fdone;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic check_full(input string tag, input int ncyc, input bit fdone, input bit chk_cyc);
        chk({tag, "_done"}, 72'(fdone), 72'd1);
        if (chk_cyc) chk({tag, "_cycles"}, 72'(ncyc), 72'd900);
        chk({tag, "_busy_after"}, 72'(busy), 72'd0);
        chk({tag, "_win_count"}, 72'(win_cnt), 72'(NWIN));
        chk({tag, "_win_errors"}, 72'(win_err), 72'd0);
        chk({tag, "_fd_count"}, 72'(fd_cnt), 72'd1);
        chk({tag, "_fd_align"}, 72'(fd_err), 72'd0);
        chk({tag, "_first_win"}, first_win, 72'h1d_1c_00_01_00_00_00_00_00);
        chk({tag, "_last_win"}, last_win, 72'h00_00_00_00_0f_0e_00_f3_f2);
    endtask

    initial begin
        // 1: reset, with start asserted during reset
        reset_n = 1'b0;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_win_valid", 72'(win_valid), 72'd0);
        chk("rst_frame_done", 72'(frame_done), 72'd0);
        chk("rst_busy", 72'(busy), 72'd0);
        chk("rst_px_ready", 72'(px_ready), 72'd0);
        chk("rst_win_data", win_data, 72'd0);
        start = 1'b0;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_busy", 72'(busy), 72'd0);

        // 2: full frame, px_valid held high
        clear_mon();
        run_frame(1'b0, -1, 1'b0, 0, cyc, done);
        check_full("s2", cyc, done, 1'b1);
`ifdef CONV_FEEDER_COORD_EN
        chk("coord_first_row", 72'(row_first), 72'd0);
        chk("coord_first_col", 72'(col_first), 72'd0);
        chk("coord_29_row", 72'(row_29), 72'd1);
        chk("coord_29_col", 72'(col_29), 72'd0);
        chk("coord_last_row", 72'(row_last), 72'd27);
        chk("coord_last_col", 72'(col_last), 72'd27);
`endif

        // 3: px_valid toggling
        clear_mon();
        run_frame(1'b1, -1, 1'b0, 0, cyc, done);
        check_full("s3", cyc, done, 1'b0);

        // 4: start re-pulsed mid-scan and in the DONE cycle
        clear_mon();
        run_frame(1'b0, 50, 1'b1, 0, cyc, done);
        check_full("s4", cyc, done, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("s4_idle_busy", 72'(busy), 72'd0);
        chk("s4_idle_fd_count", 72'(fd_cnt), 72'd1);
        chk("s4_idle_win_count", 72'(win_cnt), 72'(NWIN));

        // 5: abort after window 100, then a clean frame
        clear_mon();
        run_frame(1'b0, -1, 1'b0, 100, cyc, done);
        reset_n = 1'b0;
        #1;
        chk("s5_abort_busy", 72'(busy), 72'd0);
        chk("s5_abort_win_data", win_data, 72'd0);
        chk("s5_abort_px_ready", 72'(px_ready), 72'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("s5_abort_no_fd", 72'(fd_cnt), 72'd0);
        chk("s5_abort_frame_done", 72'(done), 72'd0);
        clear_mon();
        run_frame(1'b0, -1, 1'b0, 0, cyc, done);
        check_full("s5", cyc, done, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
